// File: rtl/exp_cordic_pkg.sv
// Shared constants and state encoding for the exp path: range reduction and hyperbolic CORDIC.
// Optional symmetric reduction window is selected with EXP_RR_SYMMETRIC_EN.
package exp_cordic_pkg;
   localparam int LN2_Q14      = 11357;
   localparam int HALF_LN2_Q14 = 5678;
   localparam int IN_FRAC      = 10;
   localparam int NUM_FRAC     = 14;
   // Inverse hyperbolic CORDIC gain (1/0.82816) in Q2.14.
   localparam int CORDIC_FACTOR = 19784;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      DONE   = 2'd2
   } state_t;
endpackage

// File: rtl/exp_range_reduce.sv
// Sequential range reduction x = k*ln2 + r, one ln2 add/subtract per clock.
// EXP_RR_SYMMETRIC_EN centres r around zero instead of [0, ln2).
module exp_range_reduce
   import exp_cordic_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int NUM_W = 16,
   parameter int K_W   = 7,
   parameter int ACC_W = 21
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic signed [IN_W-1:0]  x,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [NUM_W-1:0] r,
   output logic signed [K_W-1:0]   k,
   output logic                    out_valid,
   input  logic                    out_ready
);
   localparam logic signed [ACC_W-1:0] LN2 = ACC_W'(LN2_Q14);
`ifdef EXP_RR_SYMMETRIC_EN
   localparam logic signed [ACC_W-1:0] LO  = -ACC_W'(HALF_LN2_Q14);
   localparam logic signed [ACC_W-1:0] HI  = ACC_W'(HALF_LN2_Q14 + 1);
`else
   localparam logic signed [ACC_W-1:0] LO  = '0;
   localparam logic signed [ACC_W-1:0] HI  = ACC_W'(LN2_Q14);
`endif

   state_t                  state;
   logic signed [ACC_W-1:0] acc;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         acc       <= '0;
         k         <= '0;
         r         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  // Q6.10 -> 14 fractional bits
                  acc      <= ACC_W'(x) <<< (NUM_FRAC - IN_FRAC);
                  k        <= '0;
                  in_ready <= 1'b0;
                  state    <= REDUCE;
               end
            end
            REDUCE: begin
               if (acc < LO) begin
                  acc <= acc + LN2;
                  k   <= k - K_W'(1);
               end else if (acc >= HI) begin
                  acc <= acc - LN2;
                  k   <= k + K_W'(1);
               end else begin
                  r         <= acc[NUM_W-1:0];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_exp_range_reduce.sv
// Self-checking bench for exp_range_reduce: directed cases, random arguments, backpressure, reset.
// Honours EXP_RR_SYMMETRIC_EN to select the matching reference window.
module tb_exp_range_reduce;
   logic               clk = 1'b0;
   logic               rstn;
   logic signed [15:0] x;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] r;
   logic signed [6:0]  k;
   logic               out_valid;
   logic               out_ready;

   int checks = 0;
   int errors = 0;

   exp_range_reduce dut (
      .clk(clk), .rstn(rstn), .x(x), .in_valid(in_valid), .in_ready(in_ready),
      .r(r), .k(k), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: r = v - k*ln2 with k chosen so r lands in the reduction window.
   function automatic void model(input int xv, output int ke, output int re);
      int v, a, q;
      v = xv * 16;
`ifdef EXP_RR_SYMMETRIC_EN
      a = v + 5678;
`else
      a = v;
`endif
      q = a / 11357;
      if ((a % 11357) != 0 && a < 0) q--;
      ke = q;
      re = v - q * 11357;
   endfunction

   task automatic xfer(input int xv, input bit bp);
      int ke, re, n, rh, kh;
      model(xv, ke, re);
      @(negedge clk);
      out_ready = !bp;
      chk("in_ready_idle", int'(in_ready), 1);
      x = 16'(xv);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x = 16'($urandom);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("out_valid_seen", int'(out_valid), 1);
      chk("latency", n, (ke < 0 ? -ke : ke) + 1);
      chk("k", int'(k), ke);
      chk("r", int'(r), re);
      if (bp) begin
         rh = int'(r);
         kh = int'(k);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_r_hold", int'(r), rh);
            chk("bp_k_hold", int'(k), kh);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
         end
         @(negedge clk);
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("drain_out_valid", int'(out_valid), 0);
      chk("drain_in_ready", int'(in_ready), 1);
   endtask

   initial begin
      int ke, re;
      rstn = 1'b0; x = '0; in_valid = 1'b0; out_ready = 1'b1;
      #12;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_r", int'(r), 0);
      chk("rst_k", int'(k), 0);
      @(negedge clk); rstn = 1'b1;

      // Directed values confirm the model itself on known points.
      model(0, ke, re);      chk("model_x0_k", ke, 0);     chk("model_x0_r", re, 0);
`ifdef EXP_RR_SYMMETRIC_EN
      model(512, ke, re);    chk("model_half_k", ke, 1);   chk("model_half_r", re, -3165);
`else
      model(512, ke, re);    chk("model_half_k", ke, 0);   chk("model_half_r", re, 8192);
      model(1024, ke, re);   chk("model_one_r", re, 5027);
      model(-1024, ke, re);  chk("model_mone_k", ke, -2);  chk("model_mone_r", re, 6330);
      model(32767, ke, re);  chk("model_max_r", re, 1850);
      model(-32768, ke, re); chk("model_min_r", re, 9491);
`endif

      xfer(0, 0);
      xfer(1024, 0);
      xfer(-1024, 0);
      xfer(32767, 0);
      xfer(-32768, 0);
      xfer(512, 0);
      xfer(-512, 0);
      xfer(1024, 1);

      for (int i = 0; i < 20; i++)
         xfer(int'($signed(16'($urandom))), bit'($urandom_range(0, 3) == 0));

      // Reset in the middle of a long reduction.
      @(negedge clk);
      x = 16'sd32767; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_r", int'(r), 0);
      chk("midrst_k", int'(k), 0);
      @(negedge clk); rstn = 1'b1;
      xfer(1024, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout got 0 expected 1");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end
endmodule
